// File: rtl/i2c_uart_bridge_sched.sv
// i2c_uart_bridge_sched: buffers bytes from an I2C slave in a small FIFO and
// feeds them one at a time to a UART transmitter through a start/busy
// handshake. It asks the slave to NACK when the FIFO is full and pulses
// frame_done once every byte received before an I2C STOP has gone out.
// Optional feature: define BRIDGE_CRLF_APPEND_EN to send CR, LF at the end of
// each frame before frame_done pulses.
module i2c_uart_bridge_sched #(
   parameter int DEPTH       = 8,
   parameter int PTR_W       = 3,
   parameter int ACC_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             RST,
   input  logic [7:0]       i2c_data,
   input  logic             i2c_valid,
   input  logic             i2c_stop,
   output logic             i2c_nack,
   output logic [7:0]       uart_data,
   output logic             uart_start,
   input  logic             uart_busy,
   output logic [PTR_W:0]   fifo_count,
   output logic             overflow,
   output logic             tx_err,
   output logic             frame_done
);

   localparam int TMR_W = $clog2(ACC_TIMEOUT + 1);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_KICK      = 2'd1;
   localparam logic [1:0] S_WAIT_ACC  = 2'd2;
   localparam logic [1:0] S_WAIT_DONE = 2'd3;

   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = 1;
   localparam logic [TMR_W-1:0] TMR_ONE  = 1;
   localparam logic [TMR_W-1:0] ACC_LAST = TMR_W'(ACC_TIMEOUT - 1);

   logic [7:0]       fifo_mem [DEPTH];
   logic [1:0]       state_q, state_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [PTR_W:0]   stop_mark_q, stop_mark_d;
   logic             stop_pending_q, stop_pending_d;
   logic [7:0]       data_q, data_d;
   logic             overflow_q, overflow_d;
   logic             tx_err_q, tx_err_d;
   logic [TMR_W-1:0] acc_cnt_q, acc_cnt_d;
   logic             push, pop, close;
`ifdef BRIDGE_CRLF_APPEND_EN
   // 0: no trailer in flight, 1: CR in flight, 2: LF in flight
   logic [1:0]       crlf_q, crlf_d;
`endif

   // Next-state logic: FIFO bookkeeping, handshake sequencer and framing.
   always_comb begin
      state_d        = state_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      count_d        = count_q;
      stop_mark_d    = stop_mark_q;
      stop_pending_d = stop_pending_q;
      data_d         = data_q;
      overflow_d     = overflow_q;
      tx_err_d       = tx_err_q;
      acc_cnt_d      = acc_cnt_q;
      pop            = 1'b0;
      close          = 1'b0;
`ifdef BRIDGE_CRLF_APPEND_EN
      crlf_d         = crlf_q;
`endif
      // A full FIFO drops the byte even if a pop happens on the same edge.
      push = i2c_valid && (count_q != CNT_FULL);
      if (i2c_valid && !push) begin
         overflow_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
`ifdef BRIDGE_CRLF_APPEND_EN
            // The CR/LF trailer takes precedence over queued bytes.
            if (crlf_q == 2'd2) begin
               close  = 1'b1;
               crlf_d = 2'd0;
            end else if (crlf_q == 2'd1) begin
               if (!uart_busy) begin
                  data_d  = 8'h0A;
                  crlf_d  = 2'd2;
                  state_d = S_KICK;
               end
            end else if ((count_q != '0) && !uart_busy) begin
               pop     = 1'b1;
               data_d  = fifo_mem[rd_ptr_q];
               state_d = S_KICK;
            end else if (stop_pending_q && (stop_mark_q == '0) && !uart_busy) begin
               data_d  = 8'h0D;
               crlf_d  = 2'd1;
               state_d = S_KICK;
            end
`else
            if ((count_q != '0) && !uart_busy) begin
               pop     = 1'b1;
               data_d  = fifo_mem[rd_ptr_q];
               state_d = S_KICK;
            end else if (stop_pending_q && (stop_mark_q == '0)) begin
               close = 1'b1;
            end
`endif
         end
         S_KICK: begin
            acc_cnt_d = '0;
            state_d   = S_WAIT_ACC;
         end
         S_WAIT_ACC: begin
            // No retry on timeout: the byte is abandoned.
            if (uart_busy) begin
               state_d = S_WAIT_DONE;
            end else if (acc_cnt_q == ACC_LAST) begin
               tx_err_d = 1'b1;
               state_d  = S_IDLE;
            end else begin
               acc_cnt_d = acc_cnt_q + TMR_ONE;
            end
         end
         default: begin
            if (!uart_busy) begin
               state_d = S_IDLE;
            end
         end
      endcase

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      // stop_mark counts the bytes still owed to the open frame; loading it
      // from count_d includes a same-edge push and excludes a same-edge pop.
      if (close) begin
         stop_pending_d = 1'b0;
      end
      if (i2c_stop) begin
         stop_pending_d = 1'b1;
         stop_mark_d    = count_d;
      end else if (pop && (stop_mark_q != '0)) begin
         stop_mark_d = stop_mark_q - CNT_ONE;
      end
   end

   // Control and status registers.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_q        <= S_IDLE;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         stop_mark_q    <= '0;
         stop_pending_q <= 1'b0;
         data_q         <= '0;
         overflow_q     <= 1'b0;
         tx_err_q       <= 1'b0;
         acc_cnt_q      <= '0;
`ifdef BRIDGE_CRLF_APPEND_EN
         crlf_q         <= 2'd0;
`endif
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         stop_mark_q    <= stop_mark_d;
         stop_pending_q <= stop_pending_d;
         data_q         <= data_d;
         overflow_q     <= overflow_d;
         tx_err_q       <= tx_err_d;
         acc_cnt_q      <= acc_cnt_d;
`ifdef BRIDGE_CRLF_APPEND_EN
         crlf_q         <= crlf_d;
`endif
      end
   end

   // FIFO storage; contents need no reset since pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= i2c_data;
      end
   end

   assign uart_start = (state_q == S_KICK);
   assign i2c_nack   = (count_q == CNT_FULL);
   assign fifo_count = count_q;
   assign uart_data  = data_q;
   assign overflow   = overflow_q;
   assign tx_err     = tx_err_q;
   assign frame_done = close;

endmodule

// File: tb/tb_i2c_uart_bridge_sched.sv
// Directed testbench for i2c_uart_bridge_sched with a simple UART busy model.
module tb_i2c_uart_bridge_sched;

   logic       clk = 1'b0;
   logic       RST;
   logic [7:0] i2c_data;
   logic       i2c_valid;
   logic       i2c_stop;
   logic       i2c_nack;
   logic [7:0] uart_data;
   logic       uart_start;
   logic       uart_busy;
   logic [3:0] fifo_count;
   logic       overflow;
   logic       tx_err;
   logic       frame_done;

   always #5 clk = ~clk;

   i2c_uart_bridge_sched dut (
      .clk        (clk),
      .RST        (RST),
      .i2c_data   (i2c_data),
      .i2c_valid  (i2c_valid),
      .i2c_stop   (i2c_stop),
      .i2c_nack   (i2c_nack),
      .uart_data  (uart_data),
      .uart_start (uart_start),
      .uart_busy  (uart_busy),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .tx_err     (tx_err),
      .frame_done (frame_done)
   );

   // UART model controls (written only by the stimulus process)
   logic busy_hold = 1'b0;
   logic model_en  = 1'b1;
   int   busy_len  = 10;

   // UART model state and observation log (written only by the monitor)
   logic       m_pend = 1'b0;
   logic       m_busy = 1'b0;
   int         m_cnt = 0;
   logic [7:0] sent_q[$];
   int         start_cnt = 0;
   int         dbl_cnt = 0;
   logic       prev_start = 1'b0;
   int         fd_cnt = 0;
   int         fd_sent_at = 0;
   logic       fd_busy = 1'b0;

   assign uart_busy = busy_hold | m_busy;

   // Monitor and UART model: busy rises one cycle after a start pulse.
   always @(negedge clk) begin
      if (uart_start) begin
         sent_q.push_back(uart_data);
         start_cnt <= start_cnt + 1;
      end
      if (uart_start && prev_start) dbl_cnt <= dbl_cnt + 1;
      prev_start <= uart_start;
      if (frame_done) begin
         fd_cnt     <= fd_cnt + 1;
         fd_sent_at <= sent_q.size();
         fd_busy    <= uart_busy;
      end
      if (RST) begin
         m_pend <= 1'b0;
         m_busy <= 1'b0;
         m_cnt  <= 0;
      end else begin
         if (m_pend) begin
            m_pend <= 1'b0;
            m_busy <= 1'b1;
            m_cnt  <= busy_len - 1;
         end else if (m_busy) begin
            if (m_cnt == 0) m_busy <= 1'b0;
            else m_cnt <= m_cnt - 1;
         end
         if (uart_start && model_en) m_pend <= 1'b1;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One cycle of I2C-side stimulus, sampled at the next rising edge.
   task automatic drive(input logic v, input logic [7:0] d, input logic s);
      i2c_valid = v;
      i2c_data  = d;
      i2c_stop  = s;
      @(posedge clk);
      #1;
      i2c_valid = 1'b0;
      i2c_stop  = 1'b0;
   endtask

   task automatic wait_sent(input int n, input int budget, input string tag);
      int k = 0;
      while (sent_q.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      check_eq(tag, 32'(sent_q.size() >= n), 32'd1);
   endtask

   task automatic check_all_zero(input string pfx);
      check_eq({pfx, "_start"}, 32'(uart_start), 32'd0);
      check_eq({pfx, "_count"}, 32'(fifo_count), 32'd0);
      check_eq({pfx, "_nack"},  32'(i2c_nack),   32'd0);
      check_eq({pfx, "_ovf"},   32'(overflow),   32'd0);
      check_eq({pfx, "_txerr"}, 32'(tx_err),     32'd0);
      check_eq({pfx, "_fd"},    32'(frame_done), 32'd0);
      check_eq({pfx, "_data"},  32'(uart_data),  32'd0);
   endtask

   initial begin
      int base;
      int s0;
      int f0;
      int pushed;
      int guard;
      int first_bad;
      int n_exp;
      logic [7:0] b;
      logic [7:0] exp_q[$];
      logic [7:0] frame_exp[4];

      RST = 1'b1;
      i2c_valid = 1'b0;
      i2c_stop  = 1'b0;
      i2c_data  = 8'h00;
      tick(3);
      check_all_zero("reset");
      RST = 1'b0;
      tick(2);

      // 1: single byte, latency and single start pulse
      busy_len = 10;
      base = sent_q.size();
      s0 = start_cnt;
      drive(1'b1, 8'h67, 1'b0);
      check_eq("t1_count_after_push", 32'(fifo_count), 32'd1);
      check_eq("t1_no_start_yet", 32'(uart_start), 32'd0);
      tick(1);
      check_eq("t1_start", 32'(uart_start), 32'd1);
      check_eq("t1_data", 32'(uart_data), 32'h67);
      check_eq("t1_count_after_pop", 32'(fifo_count), 32'd0);
      tick(1);
      check_eq("t1_start_dropped", 32'(uart_start), 32'd0);
      tick(20);
      check_eq("t1_start_pulses", 32'(start_cnt - s0), 32'd1);
      check_eq("t1_sent", 32'(sent_q[base]), 32'h67);

      // 2: fill with UART held busy, overflow on the ninth byte
      busy_len = 3;
      busy_hold = 1'b1;
      base = sent_q.size();
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 8'(i), 1'b0);
         if (i == 6) begin
            check_eq("t2_count7", 32'(fifo_count), 32'd7);
            check_eq("t2_nack_at7", 32'(i2c_nack), 32'd0);
         end
         if (i == 7) begin
            check_eq("t2_count8", 32'(fifo_count), 32'd8);
            check_eq("t2_nack_at8", 32'(i2c_nack), 32'd1);
            check_eq("t2_no_ovf_yet", 32'(overflow), 32'd0);
         end
      end
      check_eq("t2_count_after_drop", 32'(fifo_count), 32'd8);
      check_eq("t2_overflow", 32'(overflow), 32'd1);
      busy_hold = 1'b0;
      wait_sent(base + 8, 400, "t2_wait_sent");
      tick(10);
      for (int i = 0; i < 8; i++) begin
         if (sent_q.size() > base + i)
            check_eq($sformatf("t2_byte%0d", i), 32'(sent_q[base + i]), 32'(i));
      end
      check_eq("t2_sent_total", 32'(sent_q.size() - base), 32'd8);
      check_eq("t2_count_empty", 32'(fifo_count), 32'd0);
      check_eq("t2_nack_clear", 32'(i2c_nack), 32'd0);
      check_eq("t2_overflow_sticky", 32'(overflow), 32'd1);

      // 3: two-byte frame closed by STOP
      busy_len = 4;
      base = sent_q.size();
      f0 = fd_cnt;
`ifdef BRIDGE_CRLF_APPEND_EN
      n_exp = 4;
      frame_exp = '{8'hA1, 8'hA2, 8'h0D, 8'h0A};
`else
      n_exp = 2;
      frame_exp = '{8'hA1, 8'hA2, 8'h00, 8'h00};
`endif
      drive(1'b1, 8'hA1, 1'b0);
      drive(1'b1, 8'hA2, 1'b0);
      drive(1'b0, 8'h00, 1'b1);
      guard = 0;
      while (fd_cnt == f0 && guard < 300) begin
         tick(1);
         guard++;
      end
      check_eq("t3_fd_seen", 32'(fd_cnt != f0), 32'd1);
      tick(10);
      check_eq("t3_fd_pulses", 32'(fd_cnt - f0), 32'd1);
      check_eq("t3_fd_after_bytes", 32'(fd_sent_at - base), 32'(n_exp));
      check_eq("t3_fd_busy_low", 32'(fd_busy), 32'd0);
      check_eq("t3_sent_total", 32'(sent_q.size() - base), 32'(n_exp));
      for (int i = 0; i < n_exp; i++) begin
         if (sent_q.size() > base + i)
            check_eq($sformatf("t3_byte%0d", i), 32'(sent_q[base + i]), 32'(frame_exp[i]));
      end

      // 4: push and pop on the same edge, then a long stream across wrap
      busy_len = 2;
      busy_hold = 1'b1;
      base = sent_q.size();
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         b = 8'h31 + 8'(i);
         exp_q.push_back(b);
         drive(1'b1, b, 1'b0);
      end
      check_eq("t4_count3", 32'(fifo_count), 32'd3);
      busy_hold = 1'b0;
      exp_q.push_back(8'h34);
      drive(1'b1, 8'h34, 1'b0);
      check_eq("t4_push_pop_same_edge", 32'(fifo_count), 32'd3);
      check_eq("t4_start_after_pop", 32'(uart_start), 32'd1);
      pushed = 0;
      guard = 0;
      while (pushed < 1000 && guard < 20000) begin
         if (!i2c_nack) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            drive(1'b1, b, 1'b0);
            pushed++;
         end else begin
            tick(1);
         end
         guard++;
      end
      check_eq("t4_pushed", 32'(pushed), 32'd1000);
      wait_sent(base + exp_q.size(), 20000, "t4_wait_sent");
      tick(10);
      first_bad = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (first_bad < 0 && (sent_q.size() <= base + i || sent_q[base + i] !== exp_q[i]))
            first_bad = i;
      end
      check_eq("t4_stream_first_bad", 32'(first_bad), 32'hFFFF_FFFF);
      check_eq("t4_sent_total", 32'(sent_q.size() - base), 32'(exp_q.size()));

      // 5: UART never answers -> timeout, then normal operation resumes
      base = sent_q.size();
      check_eq("t5_txerr_before", 32'(tx_err), 32'd0);
      model_en = 1'b0;
      drive(1'b1, 8'h55, 1'b0);
      tick(16);
      check_eq("t5_txerr_at14", 32'(tx_err), 32'd0);
      tick(1);
      check_eq("t5_txerr_at15", 32'(tx_err), 32'd1);
      model_en = 1'b1;
      drive(1'b1, 8'h66, 1'b0);
      wait_sent(base + 2, 100, "t5_wait_sent");
      tick(15);
      if (sent_q.size() >= base + 2) begin
         check_eq("t5_lost_byte", 32'(sent_q[base]), 32'h55);
         check_eq("t5_next_byte", 32'(sent_q[base + 1]), 32'h66);
      end
      check_eq("t5_txerr_sticky", 32'(tx_err), 32'd1);
      check_eq("t5_count", 32'(fifo_count), 32'd0);

      // 6: reset in WAIT_DONE with four bytes queued
      busy_len = 20;
      base = sent_q.size();
      drive(1'b1, 8'h90, 1'b0);
      tick(5);
      for (int i = 1; i < 5; i++) drive(1'b1, 8'h90 + 8'(i), 1'b0);
      check_eq("t6_queued", 32'(fifo_count), 32'd4);
      check_eq("t6_busy", 32'(uart_busy), 32'd1);
      #2;
      RST = 1'b1;
      #1;
      check_all_zero("t6_async");
      s0 = start_cnt;
      tick(2);
      check_all_zero("t6_held");
      RST = 1'b0;
      tick(10);
      check_eq("t6_no_start", 32'(start_cnt - s0), 32'd0);
      check_eq("t6_count_idle", 32'(fifo_count), 32'd0);
      drive(1'b1, 8'h77, 1'b0);
      wait_sent(base + 2, 100, "t6_wait_sent");
      if (sent_q.size() >= base + 2)
         check_eq("t6_new_byte", 32'(sent_q[base + 1]), 32'h77);
      tick(25);

      check_eq("start_single_cycle", 32'(dbl_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
